edge_event_arbiter: RTL

EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

---
 rtl/edge_event_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter: detects rising edges on N level inputs, holds one
// pending bit per channel, and presents pending channels one at a time
// through a valid/ready event port using round-robin selection. A second
// edge on a channel that is still pending is merged and flagged in a sticky
// overflow bit.
//
// Handshake: evt_valid/evt_id are registered. Once evt_valid is high it stays
// high with evt_id stable until a rising clk edge sees evt_valid & evt_ready;
// that edge is the transfer. evt_ready may toggle freely and never affects
// evt_valid combinationally.
module edge_event_arbiter #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         in,
  input  logic [N-1:0]         mask,
  output logic                 evt_valid,
  output logic [$clog2(N)-1:0] evt_id,
  input  logic                 evt_ready,
  input  logic                 ovf_clr,
  output logic [N-1:0]         ovf,
  output logic                 busy
);

  localparam int W = $clog2(N);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t         state;
  logic [N-1:0]   prev;
  logic [N-1:0]   pending;
  logic [W-1:0]   rr_ptr;

  logic [N-1:0]   edge_vec;
  logic [N-1:0]   clr_vec;
  logic           hs;
  logic           found;
  logic [W-1:0]   sel;
  logic [W-1:0]   idx_w;
  int             idx;

  assign hs       = evt_valid & evt_ready;
  assign edge_vec = in & ~prev & mask;
  assign busy     = (|pending) | evt_valid;

  // One-hot clear of the channel being transferred this cycle.
  always_comb begin
    clr_vec = '0;
    for (int i = 0; i < N; i++) begin
      clr_vec[i] = hs && (evt_id == W'(i));
    end
  end

  // Round-robin search: first pending channel at or above rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    idx_w = '0;
    for (int j = 0; j < N; j++) begin
      idx = int'(rr_ptr) + j;
      if (idx >= N) idx = idx - N;
      idx_w = W'(idx);
      if (!found && pending[idx_w]) begin
        found = 1'b1;
        sel   = idx_w;
      end
    end
  end

  // Edge history; resets to ones so a level held across reset is not an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= '1;
    else     prev <= in;
  end

  // Pending bits: a new edge wins over the clear from a same-cycle transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= (pending & ~clr_vec) | edge_vec;
  end

  // Sticky overflow: edge on a still-pending, not-being-served channel; set beats clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf <= '0;
    else     ovf <= (ovf_clr ? '0 : ovf) | (edge_vec & pending & ~clr_vec);
  end

  // Grant FSM: IDLE picks a pending channel, HOLD presents it until transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      evt_valid <= 1'b0;
      evt_id    <= '0;
      rr_ptr    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            evt_id    <= sel;
            evt_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (evt_ready) begin
            evt_valid <= 1'b0;
            rr_ptr    <= (evt_id == W'(N - 1)) ? '0 : evt_id + 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          evt_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
